// File: rtl/quad_step_decoder.sv
// ---------------------------------------------------------------------------
// quad_step_decoder
//
// Front end for the up/down counter. Turns the raw quadrature phases of an
// incremental encoder into clean, clock-synchronous step pulses plus a
// direction level, and keeps a saturating tally of illegal transitions
// (both phases changing at once), which usually point at a noisy cable or an
// encoder spinning faster than the filter can follow.
//
// Datapath, in order:
//   1. two-flop synchronizer per phase, giving s = {A, B}
//   2. glitch filter: s must hold a new value for FILTER_LEN consecutive
//      edges before it is accepted into the filtered state f
//   3. Gray-transition decoder comparing old f against the accepted value
//   4. saturating illegal-transition counter
//
// Parameters:
//   FILTER_LEN  consecutive stable samples needed to accept a new level pair
//               (1..255)
//   ERR_WIDTH   width of err_count
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   a_in, b_in  raw encoder phases, asynchronous to clk
//   en          1 = report steps/errors; 0 = suppress them (filter still
//               tracks the inputs)
//   invert_dir  1 = swap the direction sense, sampled at the accepting edge
//   err_clr     synchronous clear of err_count, wins over a coincident error
//   valid       filtered state has been primed since reset
//   step        one-cycle pulse per legal quadrature transition
//   dir         direction of the latest step, 1 = up; holds between steps
//   error       one-cycle pulse per illegal (two-bit) transition
//   err_count   saturating count of illegal transitions
// ---------------------------------------------------------------------------
module quad_step_decoder #(
    parameter int FILTER_LEN = 4,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_in,
    input  logic                 b_in,
    input  logic                 en,
    input  logic                 invert_dir,
    input  logic                 err_clr,
    output logic                 valid,
    output logic                 step,
    output logic                 dir,
    output logic                 error,
    output logic [ERR_WIDTH-1:0] err_count
);

    // Until the first acceptance the filtered state holds no meaningful
    // encoder position, so the first accepted value only primes it.
    typedef enum logic {
        ST_UNPRIMED = 1'b0,
        ST_TRACKING = 1'b1
    } prime_state_t;

    localparam logic [7:0]           RUN_TARGET = 8'(FILTER_LEN);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX    = {ERR_WIDTH{1'b1}};
    localparam logic [ERR_WIDTH-1:0] ERR_ONE    = ERR_WIDTH'(1);

    // Synchronizer flops
    logic a_meta;
    logic a_sync;
    logic b_meta;
    logic b_sync;

    // Filter state
    logic [1:0] s;
    logic [1:0] s_prev;
    logic [1:0] filt;
    logic [7:0] run_cnt;

    prime_state_t state;
    prime_state_t state_next;

    // Filter combinational results
    logic       differs;
    logic       continuing;
    logic [7:0] run_len;
    logic       accept;
    logic [1:0] filt_next;
    logic [7:0] run_next;

    // Decode combinational results
    logic                 trans_up;
    logic                 trans_down;
    logic                 trans_illegal;
    logic                 step_next;
    logic                 dir_next;
    logic                 error_next;
    logic [ERR_WIDTH-1:0] err_count_next;

    assign s     = {a_sync, b_sync};
    assign valid = (state == ST_TRACKING);

    // Two flops per phase; the first may go metastable, the second is the
    // only one the rest of the design looks at.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_meta <= 1'b0;
            a_sync <= 1'b0;
            b_meta <= 1'b0;
            b_sync <= 1'b0;
        end else begin
            a_meta <= a_in;
            a_sync <= a_meta;
            b_meta <= b_in;
            b_sync <= b_meta;
        end
    end

    // Glitch filter and priming FSM next-state logic.
    // The run counts edges at which s has held one value that differs from
    // f. A run continues only if s matches the previous sample and a run was
    // already in progress; any change of s (including a return to f) restarts
    // or kills it. Before priming every sample counts as "different" because
    // f carries no real information yet.
    always_comb begin
        state_next = state;
        filt_next  = filt;
        run_next   = 8'd0;
        differs    = (state == ST_UNPRIMED) || (s != filt);
        continuing = (s == s_prev) && (run_cnt != 8'd0);
        run_len    = continuing ? (run_cnt + 8'd1) : 8'd1;
        accept     = differs && (run_len == RUN_TARGET);

        if (accept) begin
            filt_next = s;
            run_next  = 8'd0;
            if (state == ST_UNPRIMED) begin
                state_next = ST_TRACKING;
            end
        end else if (differs) begin
            run_next = run_len;
        end
    end

    // Gray decode of old f -> accepted s, plus output and error-count
    // next values. Outputs are registered, so step/error appear the cycle
    // after the accepting edge. Priming acceptances never report anything.
    always_comb begin
        trans_up       = 1'b0;
        trans_down     = 1'b0;
        trans_illegal  = 1'b0;
        step_next      = 1'b0;
        error_next     = 1'b0;
        dir_next       = dir;
        err_count_next = err_count;

        case ({filt, s})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: trans_up      = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: trans_down    = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: trans_illegal = 1'b1;
            default: ;
        endcase

        if (accept && (state == ST_TRACKING) && en) begin
            if (trans_up || trans_down) begin
                step_next = 1'b1;
                dir_next  = trans_up ^ invert_dir;
            end else if (trans_illegal) begin
                error_next = 1'b1;
            end
        end

        if (err_clr) begin
            err_count_next = '0;
        end else if (error_next && (err_count != ERR_MAX)) begin
            err_count_next = err_count + ERR_ONE;
        end
    end

    // State register for filter, FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_prev    <= 2'b00;
            filt      <= 2'b00;
            run_cnt   <= 8'd0;
            state     <= ST_UNPRIMED;
            step      <= 1'b0;
            dir       <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
        end else begin
            s_prev    <= s;
            filt      <= filt_next;
            run_cnt   <= run_next;
            state     <= state_next;
            step      <= step_next;
            dir       <= dir_next;
            error     <= error_next;
            err_count <= err_count_next;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// ---------------------------------------------------------------------------
// tb_quad_step_decoder
//
// Directed bench for quad_step_decoder with FILTER_LEN=4, ERR_WIDTH=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// that follows each rising edge. Counting the falling edge where the inputs
// change as index 0, the rising edge that first samples a new level is N=1,
// so a step/error is expected at sample index N+FILTER_LEN+1 = 6.
// ---------------------------------------------------------------------------
module tb_quad_step_decoder;

    localparam int FILTER_LEN = 4;
    localparam int ERR_WIDTH  = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 a_in;
    logic                 b_in;
    logic                 en;
    logic                 invert_dir;
    logic                 err_clr;
    logic                 valid;
    logic                 step;
    logic                 dir;
    logic                 error;
    logic [ERR_WIDTH-1:0] err_count;

    int compared   = 0;
    int mismatched = 0;

    // Observation accumulated by apply_stimulus
    int                   obs_steps;
    int                   obs_errors;
    int                   obs_both = 0;
    int                   first_step_idx;
    int                   first_err_idx;
    int                   first_valid_idx;
    logic [ERR_WIDTH-1:0] err_at_err;
    logic                 dir_q[$];

    logic [1:0] seq_fwd [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] seq_rev [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] seq_bad [5] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b11};

    quad_step_decoder #(
        .FILTER_LEN(FILTER_LEN),
        .ERR_WIDTH (ERR_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a_in      (a_in),
        .b_in      (b_in),
        .en        (en),
        .invert_dir(invert_dir),
        .err_clr   (err_clr),
        .valid     (valid),
        .step      (step),
        .dir       (dir),
        .error     (error),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clear_obs();
        obs_steps       = 0;
        obs_errors      = 0;
        first_step_idx  = 0;
        first_err_idx   = 0;
        first_valid_idx = 0;
        err_at_err      = '0;
        dir_q.delete();
    endtask

    // Drive {a,b} at the current falling edge and hold for 'cycles' clocks,
    // recording outputs on each following falling edge. err_clr is raised
    // for the single rising edge after sample index clr_idx (0 = never).
    task automatic apply_stimulus(input logic a, input logic b,
                                  input int cycles, input int clr_idx);
        a_in = a;
        b_in = b;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk);
            if (step) begin
                obs_steps++;
                dir_q.push_back(dir);
                if (first_step_idx == 0) first_step_idx = i;
            end
            if (error) begin
                obs_errors++;
                err_at_err = err_count;
                if (first_err_idx == 0) first_err_idx = i;
            end
            if (step && error) obs_both++;
            if (valid && first_valid_idx == 0) first_valid_idx = i;
            err_clr = (i == clr_idx);
        end
    endtask

    function automatic logic first_dir();
        return (dir_q.size() > 0) ? dir_q[0] : 1'bx;
    endfunction

    initial begin
        reset      = 1'b1;
        a_in       = 1'b0;
        b_in       = 1'b0;
        en         = 1'b1;
        invert_dir = 1'b0;
        err_clr    = 1'b0;
        clear_obs();

        // Reset values
        repeat (3) @(negedge clk);
        check_output("rst_valid", valid, 0);
        check_output("rst_step", step, 0);
        check_output("rst_dir", dir, 0);
        check_output("rst_error", error, 0);
        check_output("rst_err_count", err_count, 0);
        reset = 1'b0;

        // Priming on 00
        clear_obs();
        apply_stimulus(1'b0, 1'b0, 10, 0);
        check_output("prime_valid", valid, 1);
        check_output("prime_valid_idx", first_valid_idx, 4);
        check_output("prime_steps", obs_steps, 0);
        check_output("prime_errors", obs_errors, 0);
        check_output("prime_dir", dir, 0);

        // Forward rotation: each step 6 samples after the change, dir=1
        for (int k = 0; k < 4; k++) begin
            clear_obs();
            apply_stimulus(seq_fwd[k][1], seq_fwd[k][0], 8, 0);
            check_output($sformatf("fwd%0d_steps", k), obs_steps, 1);
            check_output($sformatf("fwd%0d_idx", k), first_step_idx, 6);
            check_output($sformatf("fwd%0d_dir", k), first_dir(), 1);
            check_output($sformatf("fwd%0d_errors", k), obs_errors, 0);
        end
        check_output("fwd_err_count", err_count, 0);

        // Reverse rotation, plain then inverted
        for (int inv = 0; inv < 2; inv++) begin
            invert_dir = inv[0];
            for (int k = 0; k < 4; k++) begin
                clear_obs();
                apply_stimulus(seq_rev[k][1], seq_rev[k][0], 8, 0);
                check_output($sformatf("rev%0d_%0d_steps", inv, k), obs_steps, 1);
                check_output($sformatf("rev%0d_%0d_idx", inv, k), first_step_idx, 6);
                check_output($sformatf("rev%0d_%0d_dir", inv, k), first_dir(), inv);
            end
        end

        // Illegal jumps: dir stays 1 from the inverted reverse run
        for (int k = 0; k < 5; k++) begin
            clear_obs();
            apply_stimulus(seq_bad[k][1], seq_bad[k][0], 8, 0);
            check_output($sformatf("bad%0d_errors", k), obs_errors, 1);
            check_output($sformatf("bad%0d_err_idx", k), first_err_idx, 6);
            check_output($sformatf("bad%0d_steps", k), obs_steps, 0);
            check_output($sformatf("bad%0d_dir", k), dir, 1);
            if (k == 0) check_output("bad_count_first", err_count, 1);
        end
        check_output("bad_count_sat", err_count, 3);

        // Sixth jump 11->00 with err_clr coincident with the error edge
        clear_obs();
        apply_stimulus(1'b0, 1'b0, 8, 5);
        check_output("clr_errors", obs_errors, 1);
        check_output("clr_count_at_err", err_at_err, 0);
        check_output("clr_count_end", err_count, 0);

        // Glitch rejection (invert_dir still 1: 00->10 is down^1 = 1)
        clear_obs();
        apply_stimulus(1'b1, 1'b0, 3, 0);
        apply_stimulus(1'b0, 1'b0, 10, 0);
        check_output("glitch3_steps", obs_steps, 0);
        check_output("glitch3_errors", obs_errors, 0);
        clear_obs();
        apply_stimulus(1'b1, 1'b0, 4, 0);
        apply_stimulus(1'b0, 1'b0, 12, 0);
        check_output("glitch4_steps", obs_steps, 2);
        check_output("glitch4_dir0", (dir_q.size() > 0) ? dir_q[0] : 1'bx, 1);
        check_output("glitch4_dir1", (dir_q.size() > 1) ? dir_q[1] : 1'bx, 0);
        check_output("glitch4_errors", obs_errors, 0);

        // en gating: 00->01 suppressed, then 01->11 reported
        invert_dir = 1'b0;
        en         = 1'b0;
        clear_obs();
        apply_stimulus(1'b0, 1'b1, 8, 0);
        check_output("en0_steps", obs_steps, 0);
        check_output("en0_dir", dir, 0);
        en = 1'b1;
        clear_obs();
        apply_stimulus(1'b1, 1'b1, 8, 0);
        check_output("en1_steps", obs_steps, 1);
        check_output("en1_dir", first_dir(), 1);
        check_output("en1_errors", obs_errors, 0);
        clear_obs();
        apply_stimulus(1'b0, 1'b0, 8, 0);
        check_output("en1_jump_errors", obs_errors, 1);
        check_output("en1_jump_count", err_count, 1);

        // Reset two edges into a run on 01, released with inputs at 11
        clear_obs();
        apply_stimulus(1'b0, 1'b1, 4, 0);
        reset = 1'b1;
        a_in  = 1'b1;
        b_in  = 1'b1;
        repeat (3) @(negedge clk);
        check_output("mid_rst_valid", valid, 0);
        check_output("mid_rst_step", step, 0);
        check_output("mid_rst_dir", dir, 0);
        check_output("mid_rst_error", error, 0);
        check_output("mid_rst_err_count", err_count, 0);
        reset = 1'b0;
        clear_obs();
        apply_stimulus(1'b1, 1'b1, 8, 0);
        check_output("reprime_valid_idx", first_valid_idx, 6);
        check_output("reprime_steps", obs_steps, 0);
        check_output("reprime_errors", obs_errors, 0);
        clear_obs();
        apply_stimulus(1'b1, 1'b0, 8, 0);
        check_output("post_rst_steps", obs_steps, 1);
        check_output("post_rst_idx", first_step_idx, 6);
        check_output("post_rst_dir", first_dir(), 1);

        check_output("step_error_overlap", obs_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream stage for the up/down counter. Takes raw quadrature encoder inputs A/B and emits one-cycle `step` pulses with a `dir` level.
- `step` drives the counter's `enable`; `dir` drives its `up_down` (1 = up).
- Contains a 2-flop synchronizer, a glitch filter, a Gray-transition decoder and a saturating illegal-transition counter.

Parameters:
- FILTER_LEN, 4, consecutive stable samples needed to accept a new A/B level pair; legal range 1..255.
- ERR_WIDTH, 8, width of the illegal-transition counter.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- a_in  input  1  raw encoder phase A, asynchronous to clk
- b_in  input  1  raw encoder phase B, asynchronous to clk
- en  input  1  1 = steps and errors reported; 0 = suppressed, filter still tracks
- invert_dir  input  1  1 = swap direction sense
- err_clr  input  1  synchronous clear of err_count
- valid  output  1  filtered state initialised since reset
- step  output  1  one-cycle pulse per legal quadrature transition
- dir  output  1  direction of the latest step, 1 = up; valid in the same cycle as step
- error  output  1  one-cycle pulse per illegal (two-bit) transition
- err_count  output  ERR_WIDTH  saturating count of illegal transitions

Behaviour:
- Reset values: valid=0, step=0, dir=0, error=0, err_count=0. Synchronizer flops, filter state and run counter are all cleared.
- Reset mid-operation discards pending filter runs. The next accepted value re-primes silently, with no step or error.
- Synchronizer: a_in and b_in each pass through 2 flops, giving s = {A,B}.
- Filter operates on the 2-bit vector s:
  - Run length = consecutive edges, including the current one, at which s has held its current value and differed from the filtered state f.
  - When the run length reaches FILTER_LEN, f <= s.
  - Any change of s resets the run, including a return to f or a move to a different new value.
- Priming: while valid=0, the first acceptance loads f and sets valid=1. No step or error is produced.
- Decode, applied at an acceptance with valid=1, comparing old f with new s:
  - Forward sequence 00->01->11->10->00: raw direction up.
  - Reverse sequence 00->10->11->01->00: raw direction down.
  - dir = raw direction XOR invert_dir. step=1 for one cycle.
  - Both bits differ (00<->11, 01<->10): error=1 for one cycle. No step; dir unchanged.
- step, dir and error are registered and asserted in the cycle after the accepting edge.
- dir holds its value between steps.
- en=0: f still updates. step and error stay 0. dir and err_count are unchanged.
- Latency: the edge that first samples a new stable level is edge N. step/error goes high after edge N+FILTER_LEN+1 (FILTER_LEN=4 gives 5 cycles).
- Throughput: at most one acceptance per FILTER_LEN cycles.
- err_count:
  - Increments on each error pulse and saturates at 2^ERR_WIDTH-1.
  - err_clr sets it to 0.
  - err_clr has priority over a simultaneous error: the result is 0, but the error pulse is still emitted.
- step and error are never high together.
- invert_dir is sampled at the accepting edge. Changing it between steps has no other effect.

Test Plan:
- Forward rotation: inputs 00 held 10 cycles, then 01, 11, 10, 00, each held 8 cycles, FILTER_LEN=4 -> valid=1 after priming, no step at priming; 4 step pulses, each with dir=1 and 5 cycles after the input change; err_count=0.
- Reverse rotation, first with invert_dir=0, then repeated with invert_dir=1: sequence 00->10->11->01->00 -> 4 steps with dir=0; with invert_dir=1 the same sequence gives dir=1.
- Glitch rejection: from stable 00, A pulses high for 3 cycles, then for 4 cycles -> 3-cycle pulse gives no step and f stays 00; 4-cycle pulse gives exactly one step (dir=1), then a second step (dir=0) when A returns to 00.
- Illegal jump, saturation and clear, with ERR_WIDTH=2: from 00 jump to 11 for 8 cycles, repeat 00/11 five times -> an error pulse each time, no steps, dir unchanged; err_count saturates at 3; err_clr asserted on an error cycle gives err_count=0 and the error pulse is still seen.
- en gating: en=0 during 00->01 -> no step, f=01; en=1, then 01->11 -> a single step with dir=1 and no error.
- Reset mid-operation: reset asserted 2 cycles into a filter run on 01, released with inputs at 11 -> valid=0 until 11 is accepted, then valid=1 with no step and no error; all outputs were 0 while reset was held.
